pc_seq: RTL

Fetch/next-PC sequencer for the NPC core. It owns the architectural program counter and issues instruction-fetch requests. It waits for the datapath to finish each instruction, then selects the next PC from sequential, jump, trap and mret sources. It also detects fetch timeouts and misaligned targets, raises traps to the CSR unit, and counts retired instructions.

---
 rtl/pc_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq
// Description : Fetch/next-PC sequencer. Owns the architectural PC, issues
//               fetches, selects next PC, raises traps, counts retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    output logic [31:0] ifu_addr,
    input  logic        ifu_ack,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        exe_done,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    input  logic        trap_en,
    input  logic        mret_en,
    input  logic        halt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        trap_req,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_epc,
    output logic [31:0] instret,
    output logic        halted
);

    localparam int                 c_CNT_W     = $clog2(MAX_WAIT) + 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);
    localparam logic [3:0]         c_CAUSE_MISALIGN = 4'd0;
    localparam logic [3:0]         c_CAUSE_FETCH    = 4'd1;
    localparam logic [3:0]         c_CAUSE_ECALL    = 4'd11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [31:0]        r_instret;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_trap_req;
    logic [3:0]         r_trap_cause;
    logic [31:0]        r_trap_epc;

    logic [31:0]        w_mtvec_base;
    logic [31:0]        w_mepc_base;
    logic               w_jmp_misaligned;

    // Handler and return addresses are forced word-aligned
    assign w_mtvec_base     = mtvec & ~32'h3;
    assign w_mepc_base      = mepc & ~32'h3;
    assign w_jmp_misaligned = (jmp_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_instret    <= 32'h0;
            r_wait_cnt   <= '0;
            r_trap_req   <= 1'b0;
            r_trap_cause <= 4'h0;
            r_trap_epc   <= 32'h0;
        end else begin
            r_trap_req <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (ifu_ack) begin
                        r_inst     <= ifu_rdata;
                        r_wait_cnt <= '0;
                        r_state    <= ST_EXEC;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        // Access fault: restart fetching at the trap handler
                        r_trap_req   <= 1'b1;
                        r_trap_cause <= c_CAUSE_FETCH;
                        r_trap_epc   <= r_pc;
                        r_pc         <= w_mtvec_base;
                        r_wait_cnt   <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end

                ST_EXEC: begin
                    if (exe_done) begin
                        if (halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_FETCH;
                            if (trap_en) begin
                                r_trap_req   <= 1'b1;
                                r_trap_cause <= c_CAUSE_ECALL;
                                r_trap_epc   <= r_pc;
                                r_pc         <= w_mtvec_base;
                            end else if (mret_en) begin
                                r_pc      <= w_mepc_base;
                                r_instret <= r_instret + 32'd1;
                            end else if (jmp_en && w_jmp_misaligned) begin
                                r_trap_req   <= 1'b1;
                                r_trap_cause <= c_CAUSE_MISALIGN;
                                r_trap_epc   <= r_pc;
                                r_pc         <= w_mtvec_base;
                            end else if (jmp_en) begin
                                r_pc      <= jmp_target;
                                r_instret <= r_instret + 32'd1;
                            end else begin
                                r_pc      <= r_pc + 32'd4;
                                r_instret <= r_instret + 32'd1;
                            end
                        end
                    end
                end

                ST_HALT: begin
                    r_state <= ST_HALT;
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign ifu_req    = (r_state == ST_FETCH) && !rst;
    assign ifu_addr   = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign inst_valid = (r_state == ST_EXEC);
    assign halted     = (r_state == ST_HALT);
    assign trap_req   = r_trap_req;
    assign trap_cause = r_trap_cause;
    assign trap_epc   = r_trap_epc;
    assign instret    = r_instret;

endmodule
`default_nettype wire
